// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for mult/multu.
// It owns the architectural HI/LO registers and serves mthi/mtlo/mfhi/mflo.
// Each multiply takes WIDTH partial-product steps (RUN), then one sign-fix
// step (FIX) that writes {hi,lo}. The result lands WIDTH+1 edges after the
// start is accepted.
//
// Ports:
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset
//   start     EX-stage mult/multu is valid; accepted only in IDLE without cancel
//   isSigned  1 = mult (two's complement), 0 = multu; sampled with start
//   opA, opB  rs / rt operands; sampled with start
//   cancel    pipeline flush; aborts an in-flight multiply and blocks a start
//   hiWe/loWe mthi/mtlo write enables (honoured in IDLE only)
//   wData     mthi/mtlo write data
//   hiLoRead  EX-stage instruction is mfhi/mflo
//   busy      multiply in progress (RUN or FIX)
//   stall     combinational hold request for the pipeline front end
//   done      one-cycle pulse after HI/LO were written by a multiply
//   hi, lo    HI/LO register outputs
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wData,
  input  logic             hiLoRead,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 neg;

  // |v| for signed operands, raw value otherwise. The most negative value
  // maps onto itself, which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sgn);
    logic [WIDTH-1:0] r;
    r = v;
    if (sgn && v < 0) r = -v;
    return r;
  endfunction

  // Restore the sign of the product: full 2*WIDTH two's-complement negate.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               n);
    return n ? -p : p;
  endfunction

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hiLoRead | hiWe | loWe);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A flush squashes the whole EX-stage instruction, writes included.
          if (!cancel) begin
            if (hiWe) hi <= wData;
            if (loWe) lo <= wData;
            if (start) begin
              mcand  <= {{WIDTH{1'b0}}, magnitude(opA, isSigned)};
              mplier <= magnitude(opB, isSigned);
              neg    <= isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
              acc    <= '0;
              cnt    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          if (!cancel) begin
            {hi, lo} <= apply_sign(acc, neg);
            done     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
